// File: rtl/ad9361_multi_axis_if.sv
// ----------------------------------------------------------------------------
// ad9361_multi_axis_if
// AXI-stream bundle carrying packed AD9361 I/Q beats.
//   tvalid : beat present (master -> slave)
//   tready : slave accepts the beat (slave -> master)
//   tlast  : final beat of a burst (master -> slave)
//   tdata  : packed lanes, TDATA_WIDTH bits (master -> slave)
// ----------------------------------------------------------------------------
interface ad9361_multi_axis_if #(
  parameter int TDATA_WIDTH = 128
);
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;
  logic [TDATA_WIDTH-1:0] tdata;

  modport master (output tvalid, output tlast, output tdata, input tready);
  modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/ad9361_multi_axis.sv
// ----------------------------------------------------------------------------
// ad9361_multi_axis
// Packs NUM_CHANNELS 12-bit I/Q pairs into one AXI-stream beat, buffers the
// beats in a first-word-fall-through FIFO with a registered output stage,
// counts dropped sample sets and optionally frames fixed-length bursts.
//
// Ports
//   data_clk, data_rst     : single clock, synchronous active-high reset
//   enable                 : gates capture of new sample sets
//   valid                  : per-channel sample strobes (any one captures)
//   data_i, data_q         : channel k in bits [12k+11:12k]
//   m_axis                 : AXI-stream master (tvalid/tready/tlast/tdata)
//   fifo_level             : beats held, including the output register
//   overflow, drop_count   : sticky drop flag and saturating drop counter
//   overflow_clr           : clears overflow and drop_count
// ----------------------------------------------------------------------------
module ad9361_multi_axis #(
  parameter int NUM_CHANNELS      = 4,
  parameter int WORD_WIDTH        = 16,
  parameter int REDUCE_PRECISION  = 0,
  parameter int REVERSE_DATA      = 0,
  parameter int FIFO_DEPTH        = 16,
  parameter int USE_AXIS_TLAST    = 0,
  parameter int AXIS_BURST_LENGTH = 512,
  localparam int TDATA_WIDTH      = NUM_CHANNELS * 2 * WORD_WIDTH,
  localparam int LEVEL_WIDTH      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      data_clk,
  input  logic                      data_rst,
  input  logic                      enable,
  input  logic [NUM_CHANNELS-1:0]   valid,
  input  logic [12*NUM_CHANNELS-1:0] data_i,
  input  logic [12*NUM_CHANNELS-1:0] data_q,
  ad9361_multi_axis_if.master       m_axis,
  output logic [LEVEL_WIDTH-1:0]    fifo_level,
  output logic                      overflow,
  input  logic                      overflow_clr,
  output logic [15:0]               drop_count
);

  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int LANES      = 2 * NUM_CHANNELS;
  localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL = LEVEL_WIDTH'(FIFO_DEPTH);

  // --------------------------------------------------------------------------
  // Lane packing: lane 2m = q, lane 2m+1 = i of channel NUM_CHANNELS-1-m,
  // so channel 0's i sample lands in the top lane.
  // --------------------------------------------------------------------------
  logic [TDATA_WIDTH-1:0] packed_beat;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam int CH   = NUM_CHANNELS - 1 - gi / 2;
      localparam int DEST = (REVERSE_DATA != 0) ? (LANES - 1 - gi) : gi;
      logic signed [11:0]           raw;
      logic signed [WORD_WIDTH-1:0] ext;

      if ((gi % 2) == 1) begin : g_i
        assign raw = data_i[12*CH +: 12];
      end else begin : g_q
        assign raw = data_q[12*CH +: 12];
      end

      // Sign-extend first so the arithmetic shift keeps the sign bits.
      assign ext = WORD_WIDTH'(raw);
      assign packed_beat[DEST*WORD_WIDTH +: WORD_WIDTH] = ext >>> REDUCE_PRECISION;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Stage 1: packed beat plus write strobe.
  // --------------------------------------------------------------------------
  logic                   s1_valid_reg;
  logic [TDATA_WIDTH-1:0] s1_data_reg;

  always_ff @(posedge data_clk) begin
    if (data_rst) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
    end else begin
      s1_valid_reg <= enable & (|valid);
      s1_data_reg  <= packed_beat;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO control. level_reg counts RAM entries plus the output register, so
  // "full" covers both and total storage never exceeds FIFO_DEPTH beats.
  // --------------------------------------------------------------------------
  logic [TDATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  wr_ptr_reg;
  logic [ADDR_WIDTH-1:0]  rd_ptr_reg;
  logic [LEVEL_WIDTH-1:0] level_reg;
  logic [LEVEL_WIDTH-1:0] ram_count;
  logic                   out_valid_reg;
  logic [TDATA_WIDTH-1:0] out_data_reg;
  logic                   handshake;
  logic                   wr_accept;
  logic                   wr_drop;
  logic                   ram_load;

  assign handshake = out_valid_reg & m_axis.tready;
  assign wr_accept = s1_valid_reg & ((level_reg != FULL_LEVEL) | handshake);
  assign wr_drop   = s1_valid_reg & ~wr_accept;
  assign ram_count = level_reg - LEVEL_WIDTH'(out_valid_reg);
  // Refill the output register whenever it is empty or being consumed.
  assign ram_load  = (ram_count != '0) & (~out_valid_reg | m_axis.tready);

  always_ff @(posedge data_clk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg] <= s1_data_reg;
    end
  end

  always_ff @(posedge data_clk) begin
    if (data_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (ram_load) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      level_reg <= level_reg + LEVEL_WIDTH'(wr_accept) - LEVEL_WIDTH'(handshake);
    end
  end

  // Registered read doubles as the AXI-stream output register; it only
  // changes when empty or on a handshake, keeping tdata stable under stall.
  always_ff @(posedge data_clk) begin
    if (data_rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (ram_load) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= mem[rd_ptr_reg];
    end else if (handshake) begin
      out_valid_reg <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Drop accounting; clear wins over a same-cycle drop.
  // --------------------------------------------------------------------------
  logic        overflow_reg;
  logic [15:0] drop_count_reg;

  always_ff @(posedge data_clk) begin
    if (data_rst || overflow_clr) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else if (wr_drop) begin
      overflow_reg <= 1'b1;
      if (drop_count_reg != 16'hFFFF) begin
        drop_count_reg <= drop_count_reg + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Burst framing.
  // --------------------------------------------------------------------------
  generate
    if (USE_AXIS_TLAST != 0) begin : g_tlast
      localparam int CW = $clog2(AXIS_BURST_LENGTH);
      localparam logic [CW-1:0] LAST_BEAT = CW'(AXIS_BURST_LENGTH - 1);
      logic [CW-1:0] beat_count_reg;

      always_ff @(posedge data_clk) begin
        if (data_rst) begin
          beat_count_reg <= '0;
        end else if (handshake) begin
          beat_count_reg <= (beat_count_reg == LAST_BEAT) ? '0 : beat_count_reg + 1'b1;
        end
      end

      assign m_axis.tlast = out_valid_reg & (beat_count_reg == LAST_BEAT);
    end else begin : g_no_tlast
      assign m_axis.tlast = 1'b0;
    end
  endgenerate

  assign m_axis.tvalid = out_valid_reg;
  assign m_axis.tdata  = out_data_reg;
  assign fifo_level    = level_reg;
  assign overflow      = overflow_reg;
  assign drop_count    = drop_count_reg;

endmodule

// File: doc/ad9361_multi_axis.md
# ad9361_multi_axis

Parametrised AD9361 sample packer that serialises N channels of 12-bit I/Q into an AXI-stream master, with an internal FIFO, overflow accounting and optional fixed-length bursts. It sits between the AD9361 receive data interface and the DMA/AXI-stream fabric, replacing the fixed 4-channel, unbuffered packer. Unlike its predecessor, it absorbs back-pressure, reports dropped samples and can be gated at run time.

## Interface
- NUM_CHANNELS, 4: I/Q channel pairs, 1..4.
- WORD_WIDTH, 16: bits per I or Q lane, 12..16.
- REDUCE_PRECISION, 0: arithmetic right shift applied to each 12-bit sample, 0..4.
- REVERSE_DATA, 0: 1 mirrors lane order within the beat.
- FIFO_DEPTH, 16: beats of buffering, power of two, 4..1024.
- USE_AXIS_TLAST, 0: 1 enables burst framing.
- AXIS_BURST_LENGTH, 512: beats per burst, at least 2.
- Derived: TDATA_WIDTH = NUM_CHANNELS*2*WORD_WIDTH; LEVEL_WIDTH = log2(FIFO_DEPTH)+1.

Ports:
- data_clk, in, 1: single clock for all logic, including the AXI-stream side.
- data_rst, in, 1: synchronous, active-high reset.
- enable, in, 1: when low, input samples are ignored; samples already buffered keep draining.
- valid, in, NUM_CHANNELS: per-channel sample strobes.
- data_i, in, 12*NUM_CHANNELS: channel k occupies bits [12k+11:12k].
- data_q, in, 12*NUM_CHANNELS: laid out the same way as data_i.
- m_axis_tvalid, out, 1: AXI-stream valid.
- m_axis_tready, in, 1: AXI-stream ready.
- m_axis_tlast, out, 1: asserted on the final beat of a burst.
- m_axis_tdata, out, TDATA_WIDTH: AXI-stream data.
- fifo_level, out, LEVEL_WIDTH: beats held, counting the output register; range 0..FIFO_DEPTH.
- overflow, out, 1: sticky flag, set when any sample set has been dropped.
- overflow_clr, in, 1: clears overflow and drop_count.
- drop_count, out, 16: saturating count of dropped sample sets.

## Operation
- **Capture.** A sample set is captured when enable is high and |valid is true. All NUM_CHANNELS I/Q pairs are packed into one beat.
- **Lane order.** Lane 2m holds q of channel NUM_CHANNELS-1-m. Lane 2m+1 holds i of channel NUM_CHANNELS-1-m. Lane j occupies bits [j*WORD_WIDTH+WORD_WIDTH-1 : j*WORD_WIDTH], so i0 ends up in the top lane. REVERSE_DATA=1 maps lane j to lane 2N-1-j.
- **Lane arithmetic.** Each 12-bit sample is treated as signed and arithmetic-shifted right by REDUCE_PRECISION. The result is sign-extended to WORD_WIDTH.
- **Pipeline.**
  - Stage 1 registers the packed beat plus a write strobe.
  - Stage 2 writes the beat into the FIFO.
  - The FIFO is first-word-fall-through, with a registered output holding tdata and tvalid.
- **Write/read rules.**
  - A write is accepted if the FIFO is not full, or if a beat is read in the same cycle.
  - Otherwise the beat is dropped: overflow is set, and drop_count increments, saturating at 0xFFFF.
  - overflow_clr has priority over a drop in the same cycle: after that edge the count is 0 and the flag is 0.
- **Output handshake.**
  - m_axis_tvalid stays high until m_axis_tready is sampled high.
  - tdata and tlast are stable while tvalid is high and tready is low.
  - Once valid, tvalid never drops without a handshake.
- **tlast.**
  - A beat counter increments on each handshake.
  - tlast = tvalid & (count == AXIS_BURST_LENGTH-1). That handshake resets the counter to 0.
  - Dropped beats do not affect the counter.
  - With USE_AXIS_TLAST=0, tlast is tied to 0 and the counter is removed.
- **fifo_level.** Increments on an accepted write, decrements on a handshake, and is unchanged when both occur in the same cycle.
- **Reset.**
  - data_rst clears stage 1, FIFO pointers, the output register, the burst counter, overflow and drop_count.
  - All outputs read 0 after the reset edge: tvalid, tlast, tdata, fifo_level, overflow and drop_count.
  - A reset mid-burst discards buffered data. The next burst starts at count 0.

## Timing
- **Latency.** A sample captured at edge E gives tvalid high after edge E+2, provided the FIFO is empty and enable is high at E.
- **Throughput.** Sustained rate is one beat per cycle when tready is held high.
- **Full FIFO.** When full and tready is low, the beat arriving at the FIFO at stage 2 is dropped on that edge.
- **Enable.** enable is sampled at the capture edge only. A low at E suppresses that sample with no effect on beats already in flight.
- **Register boundaries.** All outputs are registered, except tlast, which decodes registered state.

## Test plan
- **Single sample.** NUM_CHANNELS=4, defaults, tready=1. Drive valid=4'b0001 with i0=12'h800 and q3=12'h7FF at edge 0 → tvalid is high for one cycle after edge 2; top lane = 16'hF800, bottom lane = 16'h07FF.
- **Reduced precision, reversed lanes.** REDUCE_PRECISION=2, REVERSE_DATA=1, NUM_CHANNELS=2. Drive i0=12'hFFC → lane 0 = 16'hFFFF; lane order is mirrored.
- **Overflow.** FIFO_DEPTH=4, tready=0, 10 consecutive samples → fifo_level=4, overflow=1, drop_count=6. Then release tready → exactly 4 beats emerge, equal to the first 4 samples. Pulse overflow_clr → drop_count=0.
- **Bursts.** USE_AXIS_TLAST=1, AXIS_BURST_LENGTH=4, 12 samples with tready toggling every cycle → tlast on beats 4, 8 and 12 only, held stable while stalled.
- **Enable gating and mid-burst reset.** Deassert enable during 5 samples, then assert data_rst mid-burst → those samples never appear. After the reset edge, all outputs are 0 and the next tlast arrives after AXIS_BURST_LENGTH beats.
